// File: rtl/proc_pkg.sv
// Shared constants and types for the decode-stage register file.
package proc_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/mux_8_64bit.sv
// 8:1 word-wide read mux, one instance per register-file read port.
module mux_8_64bit
  import proc_pkg::*;
(
  input  word_t     in_words [NUM_REGS],
  input  reg_addr_t sel,
  output word_t     out_word
);

  always_comb begin
    out_word = in_words[sel];
  end

endmodule

// File: rtl/regfile_8x64.sv
// 8x64 register file: two combinational read ports, one write port, pending scoreboard.
// Optional macro RF_BYPASS_EN adds same-cycle writeback-to-read forwarding.
module regfile_8x64
  import proc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] RADDR_A,
  input  logic [ADDR_W-1:0] RADDR_B,
  output logic [DATA_W-1:0] RDATA_A,
  output logic [DATA_W-1:0] RDATA_B,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              ISSUE,
  input  logic [ADDR_W-1:0] ISSUE_ADDR,
  output logic              STALL,
  output logic [NUM_REGS-1:0] PENDING
);

  word_t               regs_q [1:NUM_REGS-1];
  word_t               regs_d [1:NUM_REGS-1];
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [NUM_REGS-1:0] pending_eff;
  word_t               mux_in [NUM_REGS];
  word_t               mux_a;
  word_t               mux_b;
  word_t               rd_a;
  word_t               rd_b;

  // Writeback clears pending first so a same-edge issue to that register wins.
  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (WE && (WADDR == reg_addr_t'(i))) begin
        regs_d[i]    = WDATA;
        pending_d[i] = 1'b0;
      end
      if (ISSUE && (ISSUE_ADDR == reg_addr_t'(i))) begin
        pending_d[i] = 1'b1;
      end
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    mux_in[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      mux_in[i] = regs_q[i];
    end
  end

  mux_8_64bit u_mux_a (
    .in_words (mux_in),
    .sel      (RADDR_A),
    .out_word (mux_a)
  );

  mux_8_64bit u_mux_b (
    .in_words (mux_in),
    .sel      (RADDR_B),
    .out_word (mux_b)
  );

  always_comb begin
    rd_a        = mux_a;
    rd_b        = mux_b;
    pending_eff = pending_q;
`ifdef RF_BYPASS_EN
    if (WE && (WADDR != '0)) begin
      pending_eff[WADDR] = 1'b0;
      if (WADDR == RADDR_A) rd_a = WDATA;
      if (WADDR == RADDR_B) rd_b = WDATA;
    end
`endif
  end

  // Outputs are forced quiet while reset is held, before the first reset edge lands.
  always_comb begin
    RDATA_A = rst ? rd_a : '0;
    RDATA_B = rst ? rd_b : '0;
    PENDING = rst ? pending_q : '0;
    STALL   = rst & (pending_eff[RADDR_A] | pending_eff[RADDR_B]);
  end

endmodule

// File: tb/tb_regfile_8x64.sv
// Directed self-checking bench for regfile_8x64 (expectations follow RF_BYPASS_EN if defined).
module tb_regfile_8x64;

  logic        clk;
  logic        rst;
  logic [2:0]  raddr_a;
  logic [2:0]  raddr_b;
  logic [63:0] rdata_a;
  logic [63:0] rdata_b;
  logic        we;
  logic [2:0]  waddr;
  logic [63:0] wdata;
  logic        issue;
  logic [2:0]  issue_addr;
  logic        stall;
  logic [7:0]  pending;

  int errors = 0;
  int checks = 0;

  regfile_8x64 dut (
    .clk        (clk),
    .rst        (rst),
    .RADDR_A    (raddr_a),
    .RADDR_B    (raddr_b),
    .RDATA_A    (rdata_a),
    .RDATA_B    (rdata_b),
    .WE         (we),
    .WADDR      (waddr),
    .WDATA      (wdata),
    .ISSUE      (issue),
    .ISSUE_ADDR (issue_addr),
    .STALL      (stall),
    .PENDING    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [63:0] nib_word(input int n);
    logic [3:0] nib;
    nib = 4'(n);
    return {16{nib}};
  endfunction

  initial begin
    logic [63:0] exp_r5;
    logic        exp_st;

    rst = 1'b0; raddr_a = '0; raddr_b = '0; we = 1'b0; waddr = '0; wdata = '0;
    issue = 1'b0; issue_addr = '0;

    // Reset held for two edges
    @(negedge clk);
    tick();
    tick();
    check("rst_hold_pending", 64'(pending), 64'h0);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i);
      raddr_b = 3'(7 - i);
      #1;
      check($sformatf("rst_rdata_a_%0d", i), rdata_a, 64'h0);
      check($sformatf("rst_rdata_b_%0d", 7 - i), rdata_b, 64'h0);
      check($sformatf("rst_stall_%0d", i), 64'(stall), 64'h0);
    end
    check("rst_pending", 64'(pending), 64'h0);

    // Write R1..R7 on consecutive edges
    for (int i = 1; i < 8; i++) begin
      we = 1'b1; waddr = 3'(i); wdata = nib_word(i);
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i);
      #1;
      check($sformatf("wr_rdata_a_%0d", i), rdata_a, (i == 0) ? 64'h0 : nib_word(i));
    end
    check("wr_pending", 64'(pending), 64'h0);

    // R0 ignores writes
    we = 1'b1; waddr = 3'd0; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    we = 1'b0;
    raddr_a = 3'd0; raddr_b = 3'd0;
    #1;
    check("r0_rdata_a", rdata_a, 64'h0);
    check("r0_rdata_b", rdata_b, 64'h0);

    // Scoreboard: issue R3, then writeback clears it
    issue = 1'b1; issue_addr = 3'd3;
    tick();
    issue = 1'b0;
    raddr_a = 3'd0; raddr_b = 3'd3;
    #1;
    check("sb_pending_set", 64'(pending), 64'h08);
    check("sb_stall_b3", 64'(stall), 64'h1);
    raddr_b = 3'd4;
    #1;
    check("sb_stall_b4", 64'(stall), 64'h0);
    raddr_a = 3'd3;
    #1;
    check("sb_stall_a3", 64'(stall), 64'h1);
    raddr_a = 3'd0;
    issue = 1'b1; issue_addr = 3'd0;
    tick();
    issue = 1'b0;
    check("sb_issue_r0", 64'(pending), 64'h08);

    raddr_b = 3'd3;
    we = 1'b1; waddr = 3'd3; wdata = 64'hDEAD_BEEF_0000_0003;
    #1;
`ifdef RF_BYPASS_EN
    check("sb_wcycle_rdata_b", rdata_b, 64'hDEAD_BEEF_0000_0003);
    check("sb_wcycle_stall", 64'(stall), 64'h0);
`else
    check("sb_wcycle_rdata_b", rdata_b, 64'h3333_3333_3333_3333);
    check("sb_wcycle_stall", 64'(stall), 64'h1);
`endif
    tick();
    we = 1'b0;
    #1;
    check("sb_clr_pending", 64'(pending), 64'h00);
    check("sb_clr_stall", 64'(stall), 64'h0);
    check("sb_clr_rdata_b", rdata_b, 64'hDEAD_BEEF_0000_0003);

    // Same-cycle write and read of pending R5
    issue = 1'b1; issue_addr = 3'd5;
    tick();
    issue = 1'b0;
    check("r5_pending", 64'(pending), 64'h20);
    raddr_a = 3'd5; raddr_b = 3'd0;
    we = 1'b1; waddr = 3'd5; wdata = 64'hA5A5_A5A5_A5A5_A5A5;
    #1;
`ifdef RF_BYPASS_EN
    exp_r5 = 64'hA5A5_A5A5_A5A5_A5A5; exp_st = 1'b0;
`else
    exp_r5 = 64'h5555_5555_5555_5555; exp_st = 1'b1;
`endif
    check("r5_wcycle_rdata_a", rdata_a, exp_r5);
    check("r5_wcycle_stall", 64'(stall), 64'(exp_st));
    tick();
    we = 1'b0;
    #1;
    check("r5_after_rdata_a", rdata_a, 64'hA5A5_A5A5_A5A5_A5A5);
    check("r5_after_stall", 64'(stall), 64'h0);
    check("r5_after_pending", 64'(pending), 64'h00);

    // WE and ISSUE on R6 together: new producer wins
    we = 1'b1; waddr = 3'd6; wdata = 64'h0123_4567_89AB_CDEF;
    issue = 1'b1; issue_addr = 3'd6;
    tick();
    we = 1'b0; issue = 1'b0;
    raddr_a = 3'd6;
    #1;
    check("r6_same_rdata", rdata_a, 64'h0123_4567_89AB_CDEF);
    check("r6_same_pending", 64'(pending), 64'h40);

    // WE on R6 and ISSUE on R1 together: both apply
    we = 1'b1; waddr = 3'd6; wdata = 64'hCAFE_F00D_1234_5678;
    issue = 1'b1; issue_addr = 3'd1;
    tick();
    we = 1'b0; issue = 1'b0;
    #1;
    check("diff_rdata_r6", rdata_a, 64'hCAFE_F00D_1234_5678);
    check("diff_pending", 64'(pending), 64'h02);

    // Reset mid-operation with PENDING=7E and a colliding write
    for (int i = 2; i < 7; i++) begin
      issue = 1'b1; issue_addr = 3'(i);
      tick();
    end
    issue = 1'b0;
    check("mid_pending_7e", 64'(pending), 64'h7E);
    raddr_a = 3'd2; raddr_b = 3'd1;
    #1;
    check("mid_pre_rdata_a", rdata_a, nib_word(2));
    check("mid_pre_stall", 64'(stall), 64'h1);
    rst = 1'b0;
    we = 1'b1; waddr = 3'd2; wdata = 64'hFFFF_0000_FFFF_0000;
    issue = 1'b1; issue_addr = 3'd7;
    #1;
    check("mid_during_rdata_a", rdata_a, 64'h0);
    check("mid_during_stall", 64'(stall), 64'h0);
    check("mid_during_pending", 64'(pending), 64'h0);
    tick();
    rst = 1'b1; we = 1'b0; issue = 1'b0;
    #1;
    check("mid_after_pending", 64'(pending), 64'h0);
    check("mid_after_stall", 64'(stall), 64'h0);
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i);
      #1;
      check($sformatf("mid_after_rdata_%0d", i), rdata_a, 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_8x64.md
# regfile_8x64

Eight-entry, 64-bit register file with two combinational read ports, one write port, and a per-register pending scoreboard. It sits in the decode stage of the 5-stage pipeline. Each read port is an instance of the team's 8:1 64-bit read mux, selected by a 3-bit register address. Writeback drives the write port. Issue logic drives the scoreboard and consumes the stall output.

## Interface
- DATA_W, 64, register width
- ADDR_W, 3, register address width (NUM_REGS = 2**ADDR_W = 8)

- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-low reset; sampled on rising edge of clk
- RADDR_A  input  3  read port A register address
- RADDR_B  input  3  read port B register address
- RDATA_A  output  64  read port A data
- RDATA_B  output  64  read port B data
- WE  input  1  write enable (writeback)
- WADDR  input  3  write address
- WDATA  input  64  write data
- ISSUE  input  1  instruction issued with destination ISSUE_ADDR
- ISSUE_ADDR  input  3  destination register of the issuing instruction
- STALL  output  1  a source of the current read is pending
- PENDING  output  8  scoreboard bit per register

## Operation
- R0 is hardwired to 64'h0.
  - Writes to R0 are discarded.
  - ISSUE to R0 never sets pending.
  - PENDING[0] is always 0.
- Reads are combinational: RDATA_x = regs[RADDR_x] through the 8:1 mux.
- Write: on a rising edge with rst=1, WE=1 and WADDR≠0, regs[WADDR] ← WDATA and pending[WADDR] ← 0.
- Issue: on a rising edge with rst=1, ISSUE=1 and ISSUE_ADDR≠0, pending[ISSUE_ADDR] ← 1.
- Simultaneous WE and ISSUE to the same address: the data is written and pending ends at 1. The new producer wins.
- Simultaneous WE and ISSUE to different addresses: both take effect.
- STALL = pending_eff[RADDR_A] | pending_eff[RADDR_B].
  - pending_eff equals pending, except where the bypass rule (see Configuration) clears it.
- Reset (rst=0 at an edge):
  - All regs ← 0 and pending ← 0.
  - WE and ISSUE are ignored in that cycle.
  - A reset mid-operation discards all in-flight pending state.
- Outputs during and after reset: RDATA_A = RDATA_B = 0, PENDING = 0, STALL = 0.

## Timing
- Read latency is 0 cycles (combinational from RADDR).
- Write latency is 1 cycle: a value written at edge N is visible on RDATA from edge N onward, i.e. in cycle N+1.
- PENDING is registered.
  - A set from ISSUE at edge N is visible in cycle N+1.
  - A clear from WE at edge N is visible in cycle N+1.
- STALL is combinational from RADDR, PENDING, and (when bypass is enabled) WE/WADDR.
- No handshake on the write port. WE is a single-cycle strobe and every asserted cycle performs a write.

## Configuration
- RF_BYPASS_EN defined:
  - If WE=1, WADDR≠0 and WADDR==RADDR_x in the same cycle, RDATA_x = WDATA.
  - That register is also treated as not pending for STALL in that cycle.
  - This gives same-cycle writeback-to-decode forwarding.
- RF_BYPASS_EN undefined:
  - RDATA_x returns the old register value in the write cycle.
  - STALL still reflects the registered pending bit, so the reader waits one extra cycle.

## Structure
- Shared package proc_pkg holds:
  - constants DATA_W=64, ADDR_W=3, NUM_REGS=8
  - typedef reg_addr_t (3 bits) and word_t (64 bits)
- Sub-module: mux_8_64bit, instantiated twice, once per read port.
  - Inputs are the eight register outputs, with R0 tied to 0.
  - The bypass mux sits after it, under RF_BYPASS_EN.
- Scoreboard is an 8-bit register inside regfile_8x64; no separate module.

## Test plan
- Reset: hold rst=0 for 2 cycles, then release.
  - For every RADDR 0–7: RDATA=0, PENDING=8'h00, STALL=0.
- Write/read: write R1..R7 with 64'h1111…1 through 64'h7777…7 on consecutive edges, then sweep RADDR_A through 0–7.
  - RDATA_A=64'h0, then 64'hNNNN…N for RN.
  - Write R0=64'hFFFF…F; reading R0 still gives 0.
- Scoreboard: ISSUE R3 at edge 1 → PENDING=8'h08 in cycle 2.
  - With RADDR_B=3: STALL=1.
  - WE R3=64'hDEAD_BEEF_0000_0003 at edge 3 → PENDING=8'h00, STALL=0 in cycle 4, RDATA_B equals the written value.
- Same-cycle write and read of R5=64'hA5A5…A5:
  - With RF_BYPASS_EN: RDATA_A=64'hA5A5…A5 and STALL=0 in that cycle.
  - Without RF_BYPASS_EN: RDATA_A shows the old value and STALL=1 if R5 was pending.
- Simultaneous WE and ISSUE on R6 → R6 updated, PENDING[6]=1 in the next cycle.
- Reset mid-operation: PENDING=8'h7E and registers nonzero, assert rst=0 together with WE on R2 → the next cycle shows all regs 0, PENDING=0, and the write is lost.
